traffic_phase_scheduler: RTL and testbench

//   Round-robin phase scheduler for the three-approach intersection (e-w straight,
//   e-w left turn, n-s). Grants green to one approach at a time with min/max green

---
 rtl/traffic_phase_scheduler_if.sv | 23 ++
 rtl/traffic_phase_scheduler.sv | 153 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor inputs, light outputs and status of the three-approach intersection.
interface traffic_phase_scheduler_if;
    logic       ew_str_sensor;
    logic       ew_left_sensor;
    logic       ns_sensor;
    logic [1:0] ew_str_light;
    logic [1:0] ew_left_light;
    logic [1:0] ns_light;
    logic [1:0] phase;
    logic       busy;

    // Environment side: drives sensors, observes lights and status.
    modport master (
        output ew_str_sensor, ew_left_sensor, ns_sensor,
        input  ew_str_light, ew_left_light, ns_light, phase, busy
    );

    // Scheduler side.
    modport slave (
        input  ew_str_sensor, ew_left_sensor, ns_sensor,
        output ew_str_light, ew_left_light, ns_light, phase, busy
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Round-robin phase scheduler: one approach green at a time, min/max green,
// fixed yellow, minimum all-red clearance, no starvation of waiting approaches.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset,   // asynchronous, active-low
    traffic_phase_scheduler_if.slave  bus
);
    localparam int CW = $clog2(GREEN_MAX + 1);

    localparam logic [1:0] ST_ALLRED = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    // Approach codes double as the phase output encoding.
    localparam logic [1:0] AP_NONE    = 2'd0;
    localparam logic [1:0] AP_NS      = 2'd3;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_YELLOW = 2'd1;
    localparam logic [1:0] COL_GREEN  = 2'd2;

    localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED_CYC - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    sel_q,   sel_d;
    logic [1:0]    last_q,  last_d;
    logic [1:0]    phase_q, phase_d;
    logic          busy_q,  busy_d;
    logic [1:0]    color_d;
    logic [1:0]    light_q [1:3];
    logic [1:0]    light_d [1:3];

    // Requests indexed by approach code; bit 0 (no approach) is never set.
    logic [3:0] req;
    logic       any_req, own_req, other_req;
    logic [1:0] cand1, cand2, pick;

    assign req       = {bus.ns_sensor, bus.ew_left_sensor, bus.ew_str_sensor, 1'b0};
    assign any_req   = |req;
    assign own_req   = req[sel_q];
    assign other_req = |(req & ~(4'b0001 << sel_q));

    // Round-robin: first requester strictly after last, last itself only if alone.
    always_comb begin
        cand1 = (last_q == AP_NS) ? 2'd1 : last_q + 2'd1;
        cand2 = (cand1 == AP_NS) ? 2'd1 : cand1 + 2'd1;
        if (req[cand1])
            pick = cand1;
        else if (req[cand2])
            pick = cand2;
        else
            pick = last_q;
    end

    // Phase sequencing and cycle counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_ALLRED: begin
                if (cnt_q == AR_LAST && any_req) begin
                    state_d = ST_GREEN;
                    sel_d   = pick;
                    cnt_d   = '0;
                end else if (cnt_q != AR_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GREEN: begin
                if (cnt_q >= GMIN_LAST &&
                    (!own_req || (cnt_q >= GMAX_LAST && other_req))) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end else if (cnt_q != GMAX_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_LAST) begin
                    state_d = ST_ALLRED;
                    cnt_d   = '0;
                    last_d  = sel_q;
                    sel_d   = AP_NONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_ALLRED;
                cnt_d   = '0;
                sel_d   = AP_NONE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        color_d = COL_RED;
        if (state_d == ST_GREEN)
            color_d = COL_GREEN;
        else if (state_d == ST_YELLOW)
            color_d = COL_YELLOW;
        phase_d = (state_d == ST_ALLRED) ? AP_NONE : sel_d;
        busy_d  = (state_d != ST_ALLRED);
    end

    // Only the selected approach may show a non-red color.
    for (genvar gi = 1; gi <= 3; gi++) begin : g_light
        assign light_d[gi] = (sel_d == 2'(gi)) ? color_d : COL_RED;
    end

    // State and registered outputs; reset forces all-red idle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ALLRED;
            cnt_q      <= '0;
            sel_q      <= AP_NONE;
            last_q     <= AP_NS;
            phase_q    <= AP_NONE;
            busy_q     <= 1'b0;
            light_q[1] <= COL_RED;
            light_q[2] <= COL_RED;
            light_q[3] <= COL_RED;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            light_q[1] <= light_d[1];
            light_q[2] <= light_d[2];
            light_q[3] <= light_d[3];
        end
    end

    assign bus.ew_str_light  = light_q[1];
    assign bus.ew_left_light = light_q[2];
    assign bus.ns_light      = light_q[3];
    assign bus.phase         = phase_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a timing-rule model and
// per-cycle comparison plus literal checks of the key scenarios.
module tb_traffic_phase_scheduler;
    localparam int GMIN = 5, GMAX = 10, YEL = 2, AR = 1;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   passes = 0;
    bit   cmp_en = 1'b0;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_CYC(YEL), .ALLRED_CYC(AR)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: color shown, owner, and how long it has been shown
    int m_owner, m_color, m_age, m_last;

    function automatic bit sens(input int c);
        case (c)
            1: return bus.ew_str_sensor;
            2: return bus.ew_left_sensor;
            3: return bus.ns_sensor;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pick_next(input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = ((last - 1 + k) % 3) + 1;
            if (sens(c)) return c;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int n_owner, n_color, n_age, n_last;
        bit any, others;
        if (!reset_n) begin
            m_owner <= 0; m_color <= 0; m_age <= 1; m_last <= 3;
        end else begin
            n_owner = m_owner; n_color = m_color; n_age = m_age + 1; n_last = m_last;
            any     = sens(1) | sens(2) | sens(3);
            others  = 1'b0;
            for (int c = 1; c <= 3; c++)
                if (c != m_owner && sens(c)) others = 1'b1;
            if (m_color == 0) begin
                if (m_age >= AR && any) begin
                    n_owner = pick_next(m_last); n_color = 2; n_age = 1;
                end
            end else if (m_color == 2) begin
                if (m_age >= GMIN && (!sens(m_owner) || (m_age >= GMAX && others))) begin
                    n_color = 1; n_age = 1;
                end
            end else begin
                if (m_age >= YEL) begin
                    n_last = m_owner; n_owner = 0; n_color = 0; n_age = 1;
                end
            end
            m_owner <= n_owner; m_color <= n_color; m_age <= n_age; m_last <= n_last;
        end
    end

    // ---------------- per-cycle compare and invariants
    int prev_l [3];

    always @(negedge clk) begin : compare
        int act [3];
        int nonred;
        if (cmp_en) begin
            act[0] = bus.ew_str_light; act[1] = bus.ew_left_light; act[2] = bus.ns_light;
            for (int i = 0; i < 3; i++)
                check($sformatf("cyc_light%0d", i), act[i], (m_owner == i + 1) ? m_color : 0);
            check("cyc_phase", bus.phase, (m_color == 0) ? 0 : m_owner);
            check("cyc_busy", bus.busy, (m_color != 0) ? 1 : 0);
            nonred = 0;
            for (int i = 0; i < 3; i++) begin
                if (act[i] != 0) nonred++;
                check("inv_no_code3", int'(act[i] == 3), 0);
                check("inv_no_green_to_red", int'(reset_n && prev_l[i] == 2 && act[i] == 0), 0);
                prev_l[i] = reset_n ? act[i] : 0;
            end
            check("inv_one_nonred", int'(nonred <= 1), 1);
        end
    end

    // ---------------- directed helpers
    function automatic int get(input int idx);
        case (idx)
            0: return int'(bus.ew_str_light);
            1: return int'(bus.ew_left_light);
            2: return int'(bus.ns_light);
            default: return int'(bus.phase);
        endcase
    endfunction

    task automatic wait_for(input string name, input int idx, input int val, input int bound);
        int n = 0;
        while (get(idx) != val && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, get(idx), val);
    endtask

    task automatic run_len(input int idx, input int val, output int n);
        n = 0;
        while (get(idx) == val && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_sens(input bit s, input bit l, input bit n);
        bus.ew_str_sensor = s; bus.ew_left_sensor = l; bus.ns_sensor = n;
    endtask

    initial begin : stim
        int n;
        int exp_ph [4];
        exp_ph = '{1, 2, 3, 1};
        prev_l = '{0, 0, 0};
        reset_n = 1'b0;
        set_sens(0, 0, 0);

        // Test 1: reset then idle with no sensors
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("t1_reset_lights", {bus.ew_str_light, bus.ew_left_light, bus.ns_light}, 0);
        check("t1_reset_phase", bus.phase, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_idle_phase", bus.phase, 0);
        check("t1_idle_busy", bus.busy, 0);

        // Test 2: ew_left alone, dropped after one green cycle
        set_sens(0, 1, 0);
        wait_for("t2_grant", 1, 2, 10);
        check("t2_phase", bus.phase, 2);
        set_sens(0, 0, 0);
        run_len(1, 2, n);
        check("t2_green_len", n, 5);
        run_len(1, 1, n);
        check("t2_yellow_len", n, 2);
        repeat (5) @(negedge clk);
        check("t2_idle_phase", bus.phase, 0);

        // Test 3: all sensors high from a fresh reset
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        set_sens(1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            wait_for("t3_grant", exp_ph[i] - 1, 2, 20);
            check("t3_phase", bus.phase, exp_ph[i]);
            run_len(exp_ph[i] - 1, 2, n);
            check("t3_green_len", n, 10);
            if (i < 3) begin
                run_len(exp_ph[i] - 1, 1, n);
                check("t3_yellow_len", n, 2);
                run_len(3, 0, n);
                check("t3_red_len", n, 1);
            end
        end

        // Test 4: ns alone held, ew_left raised at green cycle 12
        set_sens(0, 0, 1);
        wait_for("t4_grant", 2, 2, 20);
        for (int g = 1; g < 12; g++) @(negedge clk);
        check("t4_green_c12", bus.ns_light, 2);
        set_sens(0, 1, 1);
        @(negedge clk);
        check("t4_yellow_next", bus.ns_light, 1);
        run_len(2, 1, n);
        check("t4_yellow_len", n, 2);
        run_len(3, 0, n);
        check("t4_red_len", n, 1);
        check("t4_ew_left_green", bus.ew_left_light, 2);
        check("t4_phase", bus.phase, 2);

        // Test 5: async reset during ns yellow, then ns as sole requester
        set_sens(0, 0, 1);
        wait_for("t5_ns_grant", 2, 2, 30);
        set_sens(0, 0, 0);
        wait_for("t5_ns_yellow", 2, 1, 20);
        #3 reset_n = 1'b0;
        #1;
        check("t5_async_lights", {bus.ew_str_light, bus.ew_left_light, bus.ns_light}, 0);
        check("t5_async_phase", bus.phase, 0);
        check("t5_async_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        set_sens(0, 0, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_ns_sole", bus.ns_light, 2);
        check("t5_phase", bus.phase, 3);
        repeat (5) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
